// File: rtl/winograd_tile_feeder.sv
// Raster pixel stream to overlapping 4x4 stride-2 tiles for the
// F(2x2,3x3) Winograd core, with tile-origin coordinates attached.
module winograd_tile_feeder #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int CW    = $clog2(IMG_W),
    parameter int RW    = $clog2(IMG_H)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    in_data,
    output logic          tile_valid,
    input  logic          tile_ready,
    output logic [127:0]  tile_data,
    output logic [RW-1:0] tile_row,
    output logic [CW-1:0] tile_col,
    output logic          frame_done
);

    logic [CW-1:0]  col_q, col_d;
    logic [RW-1:0]  row_q, row_d;
    logic [1:0]     slot_q, slot_d;
    logic [127:0]   win_q, win_d;
    logic [7:0]     lb_q [3][IMG_W];

    logic           tv_q, fd_q;
    logic [127:0]   td_q;
    logic [RW-1:0]  tr_q;
    logic [CW-1:0]  tc_q;

    logic           accept, emit, col_last, row_last;
    logic [1:0]     slot_m1, slot_m2;
    logic [7:0]     colv [4];

    assign in_ready   = !(tv_q && !tile_ready);
    assign accept     = in_valid && in_ready;
    assign col_last   = (col_q == CW'(IMG_W - 1));
    assign row_last   = (row_q == RW'(IMG_H - 1));
    assign emit       = accept && row_q[0] && col_q[0]
                        && (row_q >= RW'(3)) && (col_q >= CW'(3));

    assign tile_valid = tv_q;
    assign tile_data  = td_q;
    assign tile_row   = tr_q;
    assign tile_col   = tc_q;
    assign frame_done = fd_q;

    // Slot of row r-3 is the slot about to be overwritten by row r.
    assign slot_m1 = (slot_q == 2'd0) ? 2'd2 : slot_q - 2'd1;
    assign slot_m2 = (slot_q == 2'd2) ? 2'd0 : slot_q + 2'd1;

    assign colv[0] = lb_q[slot_q][col_q];
    assign colv[1] = lb_q[slot_m2][col_q];
    assign colv[2] = lb_q[slot_m1][col_q];
    assign colv[3] = in_data;

    always_comb begin
        win_d = win_q;
        if (accept) begin
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win_d[8*(4*i+j) +: 8] = win_q[8*(4*i+j+1) +: 8];
                end
                win_d[8*(4*i+3) +: 8] = colv[i];
            end
        end
    end

    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        slot_d = slot_q;
        if (accept) begin
            if (col_last) begin
                col_d = '0;
                if (row_last) begin
                    row_d  = '0;
                    slot_d = 2'd0;
                end else begin
                    row_d  = row_q + RW'(1);
                    slot_d = slot_m2;
                end
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // Line buffers carry no reset; rows 0..2 are rewritten before any emit.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb_q[slot_q][col_q] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q  <= '0;
            row_q  <= '0;
            slot_q <= '0;
            win_q  <= '0;
            tv_q   <= 1'b0;
            fd_q   <= 1'b0;
            td_q   <= '0;
            tr_q   <= '0;
            tc_q   <= '0;
        end else if (clear) begin
            col_q  <= '0;
            row_q  <= '0;
            slot_q <= '0;
            win_q  <= '0;
            tv_q   <= 1'b0;
            fd_q   <= 1'b0;
            td_q   <= '0;
            tr_q   <= '0;
            tc_q   <= '0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            slot_q <= slot_d;
            win_q  <= win_d;
            fd_q   <= accept && col_last && row_last;
            if (emit) begin
                tv_q <= 1'b1;
                td_q <= win_d;
                tr_q <= row_q - RW'(3);
                tc_q <= col_q - CW'(3);
            end else if (tile_ready) begin
                tv_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_winograd_tile_feeder.sv
// Directed bench for winograd_tile_feeder: frame-level model of expected
// tiles, per-cycle output comparison and literal scenario checks.
module tb_winograd_tile_feeder;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int CW = $clog2(W);
    localparam int RW = $clog2(H);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    in_data = 8'd0;
    logic          tile_valid;
    logic          tile_ready = 1'b1;
    logic [127:0]  tile_data;
    logic [RW-1:0] tile_row;
    logic [CW-1:0] tile_col;
    logic          frame_done;

    winograd_tile_feeder #(.IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .tile_valid (tile_valid),
        .tile_ready (tile_ready),
        .tile_data  (tile_data),
        .tile_row   (tile_row),
        .tile_col   (tile_col),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Frame-level model: pixels stored by frame position, tiles cut from it.
    logic [7:0]   img [H][W];
    int           mr = 0, mc = 0, macc = 0;
    bit           e_tv = 0, e_fd = 0, m_acc;
    logic [127:0] e_td = '0;
    int           e_tr = 0, e_tc = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || clear) begin
            mr = 0; mc = 0;
            e_tv = 0; e_fd = 0; e_td = '0; e_tr = 0; e_tc = 0;
        end else begin
            m_acc = in_valid && !(e_tv && !tile_ready);
            e_fd = 0;
            if (e_tv && tile_ready) e_tv = 0;
            if (m_acc) begin
                macc++;
                img[mr][mc] = in_data;
                if (mr >= 3 && mr % 2 == 1 && mc >= 3 && mc % 2 == 1) begin
                    e_tv = 1; e_tr = mr - 3; e_tc = mc - 3;
                    for (int i = 0; i < 4; i++)
                        for (int j = 0; j < 4; j++)
                            e_td[8*(4*i+j) +: 8] = img[mr-3+i][mc-3+j];
                end
                if (mr == H - 1 && mc == W - 1) e_fd = 1;
                mc++;
                if (mc == W) begin
                    mc = 0; mr++;
                    if (mr == H) mr = 0;
                end
            end
        end
    end

    typedef struct {int r; int c; logic [127:0] d; int a;} tile_t;
    typedef struct {bit tv; int r; int c; logic [7:0] e;} fd_t;
    tile_t tlog[$];
    fd_t   fdlog[$];

    always begin
        @(negedge clk);
        #2;
        chk("in_ready", in_ready, !(e_tv && !tile_ready));
        chk("tile_valid", tile_valid, e_tv);
        chk("frame_done", frame_done, e_fd);
        if (e_tv) begin
            chk("tile_data", tile_data, e_td);
            chk("tile_row", tile_row, e_tr);
            chk("tile_col", tile_col, e_tc);
        end
        if (tile_valid && tile_ready)
            tlog.push_back('{int'(tile_row), int'(tile_col), tile_data, macc});
        if (frame_done)
            fdlog.push_back('{tile_valid, int'(tile_row), int'(tile_col),
                              tile_data[7:0]});
    end

    bit  hold_ready = 0, stall_en = 0, gaps = 0;
    int  stall_r = 0, stall_c = 0, stall_len = 0, stall_cnt = 0;
    logic [7:0] stall_e00 = 8'd0;

    task automatic drive_cycle(input bit want, input logic [7:0] d,
                               output bit acc);
        @(negedge clk);
        if (hold_ready) tile_ready = 1'b0;
        else if (stall_en && tile_valid && int'(tile_row) == stall_r &&
                 int'(tile_col) == stall_c && stall_cnt < stall_len) begin
            tile_ready = 1'b0;
            stall_cnt++;
        end else tile_ready = 1'b1;
        in_valid = want && (!gaps || $urandom_range(0, 1) == 1);
        in_data = d;
        #1;
        if (stall_en && tile_valid && !tile_ready) begin
            chk("stall_in_ready", in_ready, 1'b0);
            chk("stall_e00", tile_data[7:0], stall_e00);
        end
        acc = in_valid && in_ready;
    endtask

    task automatic send(input int n, input int off, input int stop_stall);
        int k = 0;
        int cyc = 0;
        bit a;
        while (k < n) begin
            drive_cycle(1'b1, 8'(8 * (k / W) + (k % W) + off), a);
            if (a) k++;
            cyc++;
            if (stop_stall > 0 && stall_cnt >= stop_stall) break;
            if (cyc > 3000) begin
                checks++; failures++;
                $display("FAIL send_timeout accepted=%0d required=%0d", k, n);
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        bit a;
        repeat (n) drive_cycle(1'b0, 8'd0, a);
    endtask

    function automatic logic [127:0] exp_tile(int r0, int c0, int off);
        logic [127:0] t;
        t = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                t[8*(4*i+j) +: 8] = 8'(8 * (r0 + i) + (c0 + j) + off);
        return t;
    endfunction

    task automatic cmp_frame(input string nm, input int base, input int off);
        for (int k = 0; k < 9; k++) begin
            int r0, c0;
            r0 = 2 * (k / 3);
            c0 = 2 * (k % 3);
            if (base + k < tlog.size()) begin
                chk({nm, "_row"}, tlog[base+k].r, r0);
                chk({nm, "_col"}, tlog[base+k].c, c0);
                chk({nm, "_data"}, tlog[base+k].d, exp_tile(r0, c0, off));
            end else begin
                checks++; failures++;
                $display("FAIL %s_missing tile=%0d present=%0d required=9",
                         nm, k, tlog.size() - base);
            end
        end
    endtask

    int lb, fb, ab;

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_tile_valid", tile_valid, 1'b0);
        chk("rst_tile_data", tile_data, 128'd0);
        chk("rst_tile_row", tile_row, 0);
        chk("rst_tile_col", tile_col, 0);
        chk("rst_frame_done", frame_done, 1'b0);
        rst_n = 1'b1;

        // Plain frame
        lb = tlog.size(); fb = fdlog.size(); ab = macc;
        send(64, 0, 0);
        idle(3);
        cmp_frame("s1", lb, 0);
        chk("s1_count", tlog.size() - lb, 9);
        chk("s1_pix", macc - ab, 64);
        if (tlog.size() > lb) begin
            chk("s1_first_lat", tlog[lb].a - ab, 28);
            chk("s1_e00", tlog[lb].d[7:0], 8'd0);
            chk("s1_e33", tlog[lb].d[127:120], 8'd27);
        end
        chk("s1_fd_count", fdlog.size() - fb, 1);
        if (fdlog.size() > fb) begin
            chk("s1_fd_tv", fdlog[fb].tv, 1'b1);
            chk("s1_fd_row", fdlog[fb].r, 4);
            chk("s1_fd_col", fdlog[fb].c, 4);
            chk("s1_fd_e00", fdlog[fb].e, 8'd36);
        end

        // Stall on tile (0,2)
        stall_en = 1; stall_r = 0; stall_c = 2; stall_len = 5;
        stall_cnt = 0; stall_e00 = 8'd2;
        lb = tlog.size(); ab = macc;
        send(64, 0, 0);
        idle(3);
        stall_en = 0;
        cmp_frame("s2", lb, 0);
        chk("s2_count", tlog.size() - lb, 9);
        chk("s2_stall_cycles", stall_cnt, 5);
        chk("s2_pix", macc - ab, 64);

        // Random input gaps
        gaps = 1;
        lb = tlog.size(); ab = macc;
        send(64, 0, 0);
        idle(3);
        gaps = 0;
        cmp_frame("s3", lb, 0);
        chk("s3_count", tlog.size() - lb, 9);
        chk("s3_pix", macc - ab, 64);

        // Back-to-back frames
        lb = tlog.size(); fb = fdlog.size(); ab = macc;
        send(64, 0, 0);
        send(64, 100, 0);
        idle(3);
        cmp_frame("s4a", lb, 0);
        cmp_frame("s4b", lb + 9, 100);
        chk("s4_count", tlog.size() - lb, 18);
        chk("s4_fd_count", fdlog.size() - fb, 2);
        if (tlog.size() > lb + 9) begin
            chk("s4_f2_e00", tlog[lb+9].d[7:0], 8'd100);
            chk("s4_f2_lat", tlog[lb+9].a - ab, 64 + 28);
        end

        // Async reset with tile (0,0) pending
        hold_ready = 1;
        send(28, 0, 0);
        idle(1);
        chk("s5_pending", tile_valid, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("s5_rst_tv", tile_valid, 1'b0);
        chk("s5_rst_ir", in_ready, 1'b1);
        chk("s5_rst_data", tile_data, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        hold_ready = 0;
        lb = tlog.size(); ab = macc;
        send(64, 0, 0);
        idle(3);
        cmp_frame("s5", lb, 0);
        chk("s5_count", tlog.size() - lb, 9);

        // Clear while tile (2,2) is stalled
        stall_en = 1; stall_r = 2; stall_c = 2; stall_len = 100;
        stall_cnt = 0; stall_e00 = 8'd18;
        send(64, 0, 2);
        chk("s6_stalled", stall_cnt, 2);
        @(negedge clk);
        tile_ready = 1'b0;
        in_valid = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        #1;
        chk("s6_clr_ir", in_ready, 1'b1);
        chk("s6_clr_tv", tile_valid, 1'b0);
        chk("s6_clr_fd", frame_done, 1'b0);
        stall_en = 0;
        lb = tlog.size(); ab = macc;
        send(64, 0, 0);
        idle(3);
        cmp_frame("s6", lb, 0);
        chk("s6_count", tlog.size() - lb, 9);
        chk("s6_pix", macc - ab, 64);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
